// File: rtl/conditional_sum_subtractor_seq.sv
// Multi-cycle conditional-sum subtractor: one SLICE-bit group per clock, D = A - B - B_in.
// Optional signed-overflow output V is built only when CSS_OVERFLOW_EN is defined.
module conditional_sum_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out
`ifdef CSS_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Returns {borrow, difference} of one slice; the sign bit of the widened result is the borrow.
    function automatic logic [SLICE:0] slice_sub(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             bin);
        slice_sub = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [KW-1:0]    k_q, k_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
`ifdef CSS_OVERFLOW_EN
    logic             v_q, v_d;
`endif

    logic [SLICE-1:0] a_slice, b_slice;
    logic [SLICE:0]   res0, res1, res_sel;

    assign a_slice = a_q[k_q*SLICE +: SLICE];
    assign b_slice = b_q[k_q*SLICE +: SLICE];
    assign res0    = slice_sub(a_slice, b_slice, 1'b0);
    assign res1    = slice_sub(a_slice, b_slice, 1'b1);
    // Both outcomes exist before the running borrow picks one.
    assign res_sel = br_q ? res1 : res0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        d_d     = d_q;
        k_d     = k_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef CSS_OVERFLOW_EN
        v_d     = v_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    br_d    = B_in;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d[k_q*SLICE +: SLICE] = res_sel[SLICE-1:0];
                br_d = res_sel[SLICE];
                k_d  = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    d_d     = acc_d;
                    bout_d  = res_sel[SLICE];
`ifdef CSS_OVERFLOW_EN
                    v_d     = (a_q[MSB] != b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            k_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef CSS_OVERFLOW_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            k_q     <= k_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef CSS_OVERFLOW_EN
            v_q     <= v_d;
`endif
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign D     = d_q;
    assign B_out = bout_q;
`ifdef CSS_OVERFLOW_EN
    assign V     = v_q;
`endif

endmodule

// File: tb/tb_conditional_sum_subtractor_seq.sv
// Self-checking bench for conditional_sum_subtractor_seq (WIDTH=16, SLICE=4), with optional V checks.
module tb_conditional_sum_subtractor_seq;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             B_in;
    logic             busy, done;
    logic [WIDTH-1:0] D;
    logic             B_out;
`ifdef CSS_OVERFLOW_EN
    logic             V;
`endif

    int checks = 0;
    int passes = 0;

    conditional_sum_subtractor_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .B_in  (B_in),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .B_out (B_out)
`ifdef CSS_OVERFLOW_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer subtraction.
    function automatic logic [WIDTH-1:0] ref_d(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic bin);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        ref_d = diff[WIDTH-1:0];
    endfunction

    function automatic logic ref_bo(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic bin);
        ref_bo = (int'(a) < int'(b) + int'(bin));
    endfunction

    function automatic logic ref_v(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bin);
        logic [WIDTH-1:0] d;
        d = ref_d(a, b, bin);
        ref_v = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic cur_v();
`ifdef CSS_OVERFLOW_EN
        cur_v = V;
`else
        cur_v = 1'b0;
`endif
    endfunction

    // Starts one operation and waits (bounded) for done; lat is the cycle in which done was seen.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                         output int lat, output logic [WIDTH-1:0] d_o, output logic bo_o,
                         output logic v_o, output logic done_after, output logic busy_after);
        @(negedge clk);
        A = a; B = b; B_in = bin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        A = ~a; B = ~b; B_in = ~bin;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        d_o  = D;
        bo_o = B_out;
        v_o  = cur_v();
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== '0 || B_out !== 1'b0 || cur_v() !== 1'b0)
            $display("FAIL reset_state: busy=%b done=%b D=%h B_out=%b V=%b, want all zero",
                     busy, done, D, B_out, cur_v());
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] ta [5] = '{16'h1234, 16'h0100, 16'h0000, 16'h0000, 16'h8000};
        logic [WIDTH-1:0] tb [5] = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'h0000};
        logic             tbi[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] td [5] = '{16'h1000, 16'h00FF, 16'hFFFF, 16'hFFFE, 16'h7FFF};
        logic             tbo[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic             tv [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [WIDTH-1:0] d; logic bo, v, da, ba;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], tbi[i], lat, d, bo, v, da, ba);
            checks++;
            if (lat !== N + 1 || d !== td[i] || bo !== tbo[i])
                $display("FAIL directed_%0d: lat=%0d D=%h B_out=%b, want lat=%0d D=%h B_out=%b",
                         i, lat, d, bo, N + 1, td[i], tbo[i]);
            else passes++;
            checks++;
            if (da !== 1'b0 || ba !== 1'b0)
                $display("FAIL directed_pulse_%0d: done=%b busy=%b after done cycle, want 0 0", i, da, ba);
            else passes++;
`ifdef CSS_OVERFLOW_EN
            checks++;
            if (v !== tv[i]) $display("FAIL directed_v_%0d: V=%b want %b", i, v, tv[i]);
            else passes++;
`endif
        end
`ifdef CSS_OVERFLOW_EN
        do_op(16'h0005, 16'h0003, 1'b0, lat, d, bo, v, da, ba);
        checks++;
        if (v !== 1'b0 || d !== 16'h0002) $display("FAIL directed_v_small: V=%b D=%h want 0 0002", v, d);
        else passes++;
`endif
    endtask

    task automatic test_random();
        int lat; logic [WIDTH-1:0] a, b, d; logic bin, bo, v, da, ba;
        for (int i = 0; i < 40; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
            if (i % 8 == 0) b = a;
            do_op(a, b, bin, lat, d, bo, v, da, ba);
            checks++;
            if (lat !== N + 1 || d !== ref_d(a, b, bin) || bo !== ref_bo(a, b, bin) ||
                v !== (cur_v() & ref_v(a, b, bin)) || da !== 1'b0)
                $display("FAIL random_%0d: A=%h B=%h Bin=%b lat=%0d D=%h Bo=%b V=%b, want lat=%0d D=%h Bo=%b V=%b",
                         i, a, b, bin, lat, d, bo, v, N + 1, ref_d(a, b, bin), ref_bo(a, b, bin),
                         cur_v() & ref_v(a, b, bin));
            else passes++;
        end
    endtask

    task automatic test_ignore_start();
        logic [WIDTH-1:0] exp_d;
        int done_cnt = 0;
        exp_d = ref_d(16'h4321, 16'h1111, 1'b1);
        @(negedge clk);
        A = 16'h4321; B = 16'h1111; B_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            checks++;
            if (busy !== (c <= N + 1) || done !== (c == N + 1))
                $display("FAIL ignore_start_c%0d: busy=%b done=%b, want %b %b",
                         c, busy, done, (c <= N + 1), (c == N + 1));
            else passes++;
            if (c == 2 || c == 3) begin
                A = WIDTH'($urandom); B = WIDTH'($urandom); B_in = 1'b0; start = 1'b1;
            end else start = 1'b0;
        end
        checks++;
        if (done_cnt !== 1 || D !== exp_d || B_out !== 1'b0)
            $display("FAIL ignore_start_result: pulses=%0d D=%h Bo=%b, want 1 %h 0", done_cnt, D, B_out, exp_d);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d1, d2;
        int lat2 = -1;
        d1 = ref_d(16'h00F0, 16'h0F00, 1'b0);
        d2 = ref_d(16'hABCD, 16'h1234, 1'b1);
        @(negedge clk);
        A = 16'h00F0; B = 16'h0F00; B_in = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == N + 1) begin
                checks++;
                if (!done || D !== d1 || B_out !== 1'b1)
                    $display("FAIL b2b_first: done=%b D=%h Bo=%b, want 1 %h 1", done, D, B_out, d1);
                else passes++;
                A = 16'hABCD; B = 16'h1234; B_in = 1'b1;
            end else if (c > N + 1 && c < 2 * N + 3) begin
                checks++;
                if (D !== d1 || done !== 1'b0)
                    $display("FAIL b2b_hold_c%0d: D=%h done=%b, want %h 0", c, D, done, d1);
                else passes++;
            end else if (c > N + 1 && done) begin
                lat2 = c;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (lat2 !== 2 * N + 3 || D !== d2 || B_out !== 1'b0)
            $display("FAIL b2b_second: done cycle=%0d D=%h Bo=%b, want %0d %h 0", lat2, D, B_out, 2 * N + 3, d2);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int lat; logic [WIDTH-1:0] d; logic bo, v, da, ba;
        int seen = 0;
        do_op(16'h0000, 16'h0001, 1'b0, lat, d, bo, v, da, ba);
        @(negedge clk);
        A = 16'h5555; B = 16'h1111; B_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || D !== '0 || B_out !== 1'b0 || cur_v() !== 1'b0)
            $display("FAIL reset_mid: busy=%b done=%b D=%h Bo=%b V=%b, want all zero",
                     busy, done, D, B_out, cur_v());
        else passes++;
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) $display("FAIL reset_mid_quiet: %0d active cycles after reset, want 0", seen);
        else passes++;
        do_op(16'h5555, 16'h1111, 1'b0, lat, d, bo, v, da, ba);
        checks++;
        if (lat !== N + 1 || d !== 16'h4444 || bo !== 1'b0)
            $display("FAIL reset_mid_restart: lat=%0d D=%h Bo=%b, want %0d 4444 0", lat, d, bo, N + 1);
        else passes++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; B_in = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
